// File: rtl/muldiv_controller_if.sv
// EXE/DEC-side bundle of the multiply/divide controller: op request, HI/LO moves,
// architectural HI/LO view, and the hazard requests fed to the pipeline hazard logic.
interface muldiv_controller_if #(
  parameter int WIDTH = 32
);
  logic             start_EXE;
  logic [1:0]       op_EXE;
  logic [WIDTH-1:0] a_EXE;
  logic [WIDTH-1:0] b_EXE;
  logic             mthi_EXE;
  logic             mtlo_EXE;
  logic [WIDTH-1:0] wdata_EXE;
  logic             hilo_use_DEC;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall_IF;
  logic             stall_DEC;
  logic             flush_EXE;

  modport master (
    output start_EXE, op_EXE, a_EXE, b_EXE, mthi_EXE, mtlo_EXE, wdata_EXE, hilo_use_DEC,
    input  hi, lo, busy, done, stall_IF, stall_DEC, flush_EXE
  );

  modport slave (
    input  start_EXE, op_EXE, a_EXE, b_EXE, mthi_EXE, mtlo_EXE, wdata_EXE, hilo_use_DEC,
    output hi, lo, busy, done, stall_IF, stall_DEC, flush_EXE
  );
endinterface

// File: rtl/muldiv_controller.sv
// Iterative mult/multu/div/divu sequencer owning HI/LO, one result bit per cycle.
// Latency: start in cycle 0, busy cycles 1..WIDTH+1, result and done in cycle WIDTH+2.
// Backpressure: stalls IF/DEC and flushes EXE while a DEC instruction needs HI/LO or the unit.
module muldiv_controller #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_controller_if.slave mdu
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd_b;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div0;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_tmp;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    signed_op = ~mdu.op_EXE[0];
    a_neg     = signed_op & mdu.a_EXE[WIDTH-1];
    b_neg     = signed_op & mdu.b_EXE[WIDTH-1];
    a_mag     = a_neg ? -mdu.a_EXE : mdu.a_EXE;
    b_mag     = b_neg ? -mdu.b_EXE : mdu.b_EXE;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_b} : {(WIDTH+1){1'b0}});

    // Divide: acc = {partial remainder, remaining dividend / quotient bits}, shifted left.
    // The partial remainder never exceeds the divisor, so the W-bit remainder cannot overflow.
    div_tmp   = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_tmp >= {1'b0, opnd_b});
    div_rem   = div_ge ? WIDTH'(div_tmp - {1'b0, opnd_b}) : div_tmp[WIDTH-1:0];

    prod      = neg_res ? -acc : acc;
    quo       = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem       = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd_b  <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mdu.start_EXE) begin
            state   <= CALC;
            cnt     <= CW'(WIDTH-1);
            is_div  <= mdu.op_EXE[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div0    <= (mdu.b_EXE == '0);
            acc     <= {{WIDTH{1'b0}}, (mdu.op_EXE[1] ? a_mag : b_mag)};
            opnd_b  <= mdu.op_EXE[1] ? b_mag : a_mag;
          end else begin
            if (mdu.mthi_EXE) hi_q <= mdu.wdata_EXE;
            if (mdu.mtlo_EXE) lo_q <= mdu.wdata_EXE;
          end
        end
        CALC: begin
          acc <= is_div ? {div_rem, acc[WIDTH-2:0], div_ge}
                        : {mul_sum, acc[WIDTH-1:1]};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          if (is_div) begin
            // Remainder sign-correction already returns the original dividend on /0.
            hi_q <= rem;
            lo_q <= div0 ? {WIDTH{1'b1}} : quo;
          end else begin
            hi_q <= prod[2*WIDTH-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mdu.hi        = hi_q;
  assign mdu.lo        = lo_q;
  assign mdu.done      = done_q;
  assign mdu.busy      = (state != IDLE);
  assign mdu.stall_IF  = mdu.hilo_use_DEC & ((state != IDLE) | (mdu.start_EXE & (state == IDLE)));
  assign mdu.stall_DEC = mdu.stall_IF;
  assign mdu.flush_EXE = mdu.stall_IF;
endmodule

// File: tb/tb_muldiv_controller.sv
// Directed bench for muldiv_controller: vector table of mult/div ops plus HI/LO move and reset sequences.
module tb_muldiv_controller;
  logic clk;
  logic reset;
  int   tests;
  int   failed;

  muldiv_controller_if #(.WIDTH(32)) mif ();

  muldiv_controller #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && mif.start_EXE && mif.busy) begin
      failed++;
      $display("FAIL start_while_busy: start_EXE=1 busy=1 expected no overlap");
    end
  end

  // Issues one op at cycle 0 with a HI/LO consumer held in DEC, then follows it to completion.
  task automatic run_op(input vec_t v);
    logic [31:0] hi0;
    logic [31:0] lo0;
    int          bad;
    hi0 = mif.hi;
    lo0 = mif.lo;
    mif.op_EXE       = v.op;
    mif.a_EXE        = v.a;
    mif.b_EXE        = v.b;
    mif.start_EXE    = 1'b1;
    mif.hilo_use_DEC = 1'b1;
    #1;
    check({v.name, " stall_c0"}, 64'(mif.stall_IF & mif.stall_DEC & mif.flush_EXE), 64'd1);
    check({v.name, " busy_c0"}, 64'(mif.busy), 64'd0);
    tick();
    mif.start_EXE = 1'b0;
    mif.a_EXE     = 32'hDEADBEEF;
    mif.b_EXE     = 32'h0BADF00D;
    bad = 0;
    for (int c = 1; c <= 33; c++) begin
      if (!mif.busy || !mif.stall_IF || !mif.stall_DEC || !mif.flush_EXE || mif.done ||
          mif.hi !== hi0 || mif.lo !== lo0)
        bad++;
      tick();
    end
    check({v.name, " calc_window_bad_cycles"}, 64'(bad), 64'd0);
    check({v.name, " hi"}, 64'(mif.hi), 64'(v.exp_hi));
    check({v.name, " lo"}, 64'(mif.lo), 64'(v.exp_lo));
    check({v.name, " done_c34"}, 64'(mif.done), 64'd1);
    check({v.name, " busy_c34"}, 64'(mif.busy), 64'd0);
    check({v.name, " stall_c34"}, 64'(mif.stall_IF | mif.stall_DEC | mif.flush_EXE), 64'd0);
    mif.hilo_use_DEC = 1'b0;
    tick();
    check({v.name, " done_c35"}, 64'(mif.done), 64'd0);
  endtask

  initial begin
    logic [31:0] lo_prev;
    int          n;
    vec_t        tail;

    tests  = 0;
    failed = 0;
    vecs[0] = '{"mult 7*-3",        2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{"multu max*max",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{"div -7/2",         2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"divu 100/7",       2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4] = '{"divu 5/0",         2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[5] = '{"div min/-1",       2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{"multu 2^16*2^16",  2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[7] = '{"div -7/0",         2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[8] = '{"div 7/-2",         2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9] = '{"mult -1*-1",       2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

    reset            = 1'b1;
    mif.start_EXE    = 1'b0;
    mif.op_EXE       = 2'b00;
    mif.a_EXE        = '0;
    mif.b_EXE        = '0;
    mif.mthi_EXE     = 1'b0;
    mif.mtlo_EXE     = 1'b0;
    mif.wdata_EXE    = '0;
    mif.hilo_use_DEC = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset hi", 64'(mif.hi), 64'd0);
    check("reset lo", 64'(mif.lo), 64'd0);
    check("reset busy", 64'(mif.busy), 64'd0);
    check("reset done", 64'(mif.done), 64'd0);
    check("reset stall", 64'(mif.stall_IF | mif.stall_DEC | mif.flush_EXE), 64'd0);
    mif.hilo_use_DEC = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // mthi in IDLE lands next cycle without a done pulse.
    lo_prev       = mif.lo;
    mif.mthi_EXE  = 1'b1;
    mif.wdata_EXE = 32'h12345678;
    tick();
    mif.mthi_EXE  = 1'b0;
    check("mthi hi", 64'(mif.hi), 64'h12345678);
    check("mthi lo kept", 64'(mif.lo), 64'(lo_prev));
    check("mthi done", 64'(mif.done), 64'd0);

    // mtlo alongside start: the op wins, the move is dropped.
    mif.mtlo_EXE  = 1'b1;
    mif.wdata_EXE = 32'hAAAA5555;
    mif.start_EXE = 1'b1;
    mif.op_EXE    = 2'b00;
    mif.a_EXE     = 32'd3;
    mif.b_EXE     = 32'd5;
    tick();
    mif.mtlo_EXE  = 1'b0;
    mif.start_EXE = 1'b0;
    check("mtlo+start lo kept", 64'(mif.lo), 64'(lo_prev));
    check("mtlo+start busy", 64'(mif.busy), 64'd1);
    n = 1;
    while (!mif.done && n < 40) begin
      tick();
      n++;
    end
    check("mult 3*5 latency", 64'(n), 64'd34);
    check("mult 3*5 hi", 64'(mif.hi), 64'd0);
    check("mult 3*5 lo", 64'(mif.lo), 64'd15);
    tick();

    mif.mtlo_EXE  = 1'b1;
    mif.wdata_EXE = 32'hCAFEF00D;
    tick();
    mif.mtlo_EXE  = 1'b0;
    check("mtlo lo", 64'(mif.lo), 64'hCAFEF00D);
    check("mtlo done", 64'(mif.done), 64'd0);

    // Reset during cycle 10 of a divide abandons it.
    mif.op_EXE    = 2'b11;
    mif.a_EXE     = 32'd100;
    mif.b_EXE     = 32'd7;
    mif.start_EXE = 1'b1;
    tick();
    mif.start_EXE = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    reset            = 1'b1;
    mif.hilo_use_DEC = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midop reset busy", 64'(mif.busy), 64'd0);
    check("midop reset hi", 64'(mif.hi), 64'd0);
    check("midop reset lo", 64'(mif.lo), 64'd0);
    check("midop reset done", 64'(mif.done), 64'd0);
    check("midop reset stall", 64'(mif.stall_IF | mif.stall_DEC | mif.flush_EXE), 64'd0);
    tick();

    tail = '{"mult 6*7 after reset", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42};
    run_op(tail);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/muldiv_controller.md
Name: muldiv_controller

Overview:
- Sequences the shared iterative multiply/divide unit and owns the HI/LO registers for the MIPS pipeline.
- Accepts a mult/multu/div/divu op from EXE and runs one bit per cycle.
- Raises stall/flush requests while any DEC instruction needs HI/LO or the unit; these are OR-ed with the load-use hazard stalls in the hazard logic.

Parameters:
WIDTH, 32, operand/HI/LO width; compute phase lasts WIDTH cycles

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start_EXE  in  1  valid mult/div instruction in EXE
op_EXE  in  2  00 mult, 01 multu, 10 div, 11 divu
a_EXE  in  WIDTH  rs operand (multiplicand/dividend)
b_EXE  in  WIDTH  rt operand (multiplier/divisor)
mthi_EXE  in  1  write HI from wdata_EXE
mtlo_EXE  in  1  write LO from wdata_EXE
wdata_EXE  in  WIDTH  mthi/mtlo data
hilo_use_DEC  in  1  DEC holds mfhi/mflo/mthi/mtlo/mult/div
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  unit not IDLE
done  out  1  one-cycle pulse: new HI/LO visible
stall_IF  out  1  hold PC
stall_DEC  out  1  hold IF/DEC register
flush_EXE  out  1  insert bubble into EXE

Behaviour:
- Reset (synchronous, wins over everything, including mid-operation): state=IDLE; hi=0, lo=0; busy=0, done=0; all stall/flush outputs 0; in-flight op discarded.
- States: IDLE, CALC, FIX.
  - IDLE -> CALC on start_EXE (operands latched, cycle 0).
  - CALC runs exactly WIDTH cycles (bit counter WIDTH-1 down to 0), then -> FIX.
  - FIX lasts 1 cycle, writes hi/lo, -> IDLE.
- Latency: start at cycle 0; busy=1 cycles 1..WIDTH+1; new hi/lo and done=1 in cycle WIDTH+2 (34 for WIDTH=32).
- busy = (state != IDLE), registered-state decode.
- Hazard: stall_IF = stall_DEC = flush_EXE = hilo_use_DEC & (busy | (start_EXE & state==IDLE)). Deasserts in the first IDLE cycle, when hi/lo already hold the result.
- start_EXE while busy cannot occur under the hazard rule. If it does, it is ignored; the bench flags it as an assertion failure.
- Sign handling:
  - Signed ops take magnitudes at start.
  - FIX negates the product if operand signs differ.
  - FIX negates the quotient if signs differ; the remainder takes the dividend's sign.
- Multiply: shift-add, 2*WIDTH-bit accumulator; hi=upper, lo=lower WIDTH bits.
- Divide: restoring, one quotient bit per cycle; lo=quotient, hi=remainder.
- Divide by zero (div or divu): lo=all ones, hi=original a_EXE; still full latency.
- Signed overflow (-2^(WIDTH-1) / -1): lo=0x80000000, hi=0.
- mthi_EXE/mtlo_EXE: write the register in the next cycle, only in IDLE with no start_EXE. start_EXE has priority; writes while busy are ignored (hazard rule prevents them).
- done: registered, high exactly one cycle (the FIX->IDLE edge), never on mthi/mtlo.
- hi/lo hold their values in all other cycles; outputs stay stable during CALC.

Test Plan:
- mult 7 x 0xFFFFFFFD (-3) at cycle 0 -> busy cycles 1..33; cycle 34: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done=1 for one cycle.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 100/7 -> lo=14, hi=2; divu 5/0 -> lo=0xFFFFFFFF, hi=5; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start at cycle 0 with hilo_use_DEC=1 from cycle 0 (mflo behind mult) -> stall_IF/stall_DEC/flush_EXE high cycles 0..33, low at 34; mflo then sees the result.
- mthi_EXE with wdata 0x12345678 while IDLE -> hi=0x12345678 next cycle, done=0; mtlo_EXE with start_EXE in the same cycle -> mtlo ignored, op runs.
- reset asserted at cycle 10 of a divide -> next cycle IDLE, hi=lo=0, busy=0, stalls 0; a new mult accepted right after completes normally.
